// File: rtl/out_sram_write_arbiter_if.sv
// Bank write-back request/grant stream bundle plus the output SRAM write port.
// The slave modport is the arbiter; the master modport is the bank/SRAM side.
interface out_sram_write_arbiter_if #(
    parameter int NUM_BANKS = 4,
    parameter int FV_SIZE   = 8,
    parameter int NODE_ID_W = 10,
    parameter int ADDR_W    = 13
);
    logic [NUM_BANKS-1:0]             bank_req;
    logic [NUM_BANKS-1:0]             bank_valid;
    logic [NUM_BANKS-1:0]             bank_sos;
    logic [NUM_BANKS-1:0]             bank_eos;
    logic [NUM_BANKS*2*FV_SIZE-1:0]   bank_data;
    logic [NUM_BANKS*NODE_ID_W-1:0]   bank_node_id;
    logic [NUM_BANKS-1:0]             req_grant;
    logic                             sram_wen;
    logic [ADDR_W-1:0]                sram_waddr;
    logic [2*FV_SIZE-1:0]             sram_wdata;
    logic                             busy;
    logic                             stream_done;
    logic                             err_overflow;
    logic                             err_no_sos;

    modport slave (
        input  bank_req, bank_valid, bank_sos, bank_eos, bank_data, bank_node_id,
        output req_grant, sram_wen, sram_waddr, sram_wdata, busy, stream_done,
        output err_overflow, err_no_sos
    );

    modport master (
        output bank_req, bank_valid, bank_sos, bank_eos, bank_data, bank_node_id,
        input  req_grant, sram_wen, sram_waddr, sram_wdata, busy, stream_done,
        input  err_overflow, err_no_sos
    );
endinterface

// File: rtl/out_sram_write_arbiter.sv
// Grants one edge-buffer bank at a time and writes its sos/eos beat stream to the output SRAM.
// Define OSW_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module out_sram_write_arbiter #(
    parameter int NUM_BANKS  = 4,
    parameter int FV_SIZE    = 8,
    parameter int MAX_FV_NUM = 16,
    parameter int NODE_ID_W  = 10,
    parameter int ADDR_W     = NODE_ID_W + $clog2(MAX_FV_NUM/2)
) (
    input  logic                     clk,
    input  logic                     reset,
    out_sram_write_arbiter_if.slave  bif
);
    localparam int WPN    = MAX_FV_NUM / 2;
    localparam int OFF_W  = $clog2(WPN);
    localparam int IDX_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BEAT_W = 2 * FV_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RECV} state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [OFF_W:0]         r_off;
    logic [NODE_ID_W-1:0]   r_node;
    logic [NUM_BANKS-1:0]   r_grant;
    logic                   r_wen;
    logic [ADDR_W-1:0]      r_waddr;
    logic [BEAT_W-1:0]      r_wdata;
    logic                   r_done;
    logic                   r_err_ovf;
    logic                   r_err_nosos;

    logic [IDX_W:0]         w_pick;
    logic [IDX_W-1:0]       w_ptr;
    logic [IDX_W-1:0]       w_rr_next;
    logic                   w_valid;
    logic                   w_sos;
    logic                   w_eos;
    logic [BEAT_W-1:0]      w_data;
    logic [NODE_ID_W-1:0]   w_node;

    // Cyclic search starting at ptr; returns {found, index}.
    function automatic logic [IDX_W:0] pick_req(input logic [NUM_BANKS-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            j = (int'(ptr) + k) % NUM_BANKS;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        return {found, idx};
    endfunction

`ifdef OSW_FIXED_PRIO_EN
    assign w_ptr     = '0;
    assign w_rr_next = '0;
`else
    assign w_ptr     = r_rr_ptr;
    assign w_rr_next = (r_idx == IDX_W'(NUM_BANKS-1)) ? '0 : r_idx + IDX_W'(1);
`endif

    assign w_pick  = pick_req(bif.bank_req, w_ptr);
    assign w_valid = bif.bank_valid[r_idx];
    assign w_sos   = bif.bank_sos[r_idx];
    assign w_eos   = bif.bank_eos[r_idx];
    assign w_data  = bif.bank_data[r_idx*BEAT_W +: BEAT_W];
    assign w_node  = bif.bank_node_id[r_idx*NODE_ID_W +: NODE_ID_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_rr_ptr    <= '0;
            r_off       <= '0;
            r_grant     <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_nosos <= 1'b0;
        end else begin
            r_grant <= '0;
            r_wen   <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick[IDX_W]) begin
                        r_idx   <= w_pick[IDX_W-1:0];
                        r_grant <= NUM_BANKS'(1) << w_pick[IDX_W-1:0];
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // The granted bank answers combinationally while the grant is high.
                    if (w_valid && w_sos) begin
                        r_node  <= w_node;
                        r_wen   <= 1'b1;
                        r_waddr <= {w_node, OFF_W'(0)};
                        r_wdata <= w_data;
                        if (w_eos) begin
                            r_done   <= 1'b1;
                            r_off    <= '0;
                            r_rr_ptr <= w_rr_next;
                            r_state  <= S_IDLE;
                        end else begin
                            r_off   <= (OFF_W+1)'(1);
                            r_state <= S_RECV;
                        end
                    end else begin
                        r_err_nosos <= 1'b1;
                        r_rr_ptr    <= w_rr_next;
                        r_state     <= S_IDLE;
                    end
                end
                S_RECV: begin
                    if (w_valid) begin
                        if (r_off < (OFF_W+1)'(WPN)) begin
                            r_wen   <= 1'b1;
                            r_waddr <= {r_node, r_off[OFF_W-1:0]};
                            r_wdata <= w_data;
                            r_off   <= r_off + (OFF_W+1)'(1);
                        end else begin
                            r_err_ovf <= 1'b1;
                        end
                        // A suppressed eos beat still closes the stream.
                        if (w_eos) begin
                            r_done   <= 1'b1;
                            r_off    <= '0;
                            r_rr_ptr <= w_rr_next;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bif.req_grant    = r_grant;
    assign bif.sram_wen     = r_wen;
    assign bif.sram_waddr   = r_waddr;
    assign bif.sram_wdata   = r_wdata;
    assign bif.busy         = (r_state != S_IDLE);
    assign bif.stream_done  = r_done;
    assign bif.err_overflow = r_err_ovf;
    assign bif.err_no_sos   = r_err_nosos;
endmodule

// File: tb/tb_out_sram_write_arbiter.sv
// Directed scoreboard bench: stimulus pushes expected grants/writes, a monitor pops and compares.
module tb_out_sram_write_arbiter;
    localparam int NUM_BANKS = 4;
    localparam int FV_SIZE   = 8;
    localparam int NODE_ID_W = 10;
    localparam int ADDR_W    = 13;
    localparam int WPN       = 8;

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic              done;
    } wr_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [15:0] beats [0:15];
    wr_t         wq[$];
    logic [3:0]  gq[$];

    out_sram_write_arbiter_if #(.NUM_BANKS(NUM_BANKS), .FV_SIZE(FV_SIZE),
                                .NODE_ID_W(NODE_ID_W), .ADDR_W(ADDR_W)) bif ();

    out_sram_write_arbiter dut (.clk(clk), .reset(reset), .bif(bif));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t        e;
        logic [3:0] g;
        forever begin
            @(negedge clk);
            if (bif.req_grant != 4'b0) begin
                if (gq.size() == 0) chk("unexpected_grant", bif.req_grant, 0);
                else begin
                    g = gq.pop_front();
                    chk("grant", bif.req_grant, g);
                end
            end
            if (bif.sram_wen || bif.stream_done) begin
                if (wq.size() == 0) chk("unexpected_write", {bif.sram_wen, bif.stream_done}, 0);
                else begin
                    e = wq.pop_front();
                    chk("wr_wen", bif.sram_wen, e.wen);
                    chk("wr_done", bif.stream_done, e.done);
                    if (e.wen) begin
                        chk("wr_addr", bif.sram_waddr, e.addr);
                        chk("wr_data", bif.sram_wdata, e.data);
                    end
                end
            end
        end
    endtask

    task automatic clear_banks();
        bif.bank_req     = '0;
        bif.bank_valid   = '0;
        bif.bank_sos     = '0;
        bif.bank_eos     = '0;
        bif.bank_data    = '0;
        bif.bank_node_id = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        clear_banks();
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, bif.req_grant, 0);
        chk({tag, "_wen"}, bif.sram_wen, 0);
        chk({tag, "_waddr"}, bif.sram_waddr, 0);
        chk({tag, "_wdata"}, bif.sram_wdata, 0);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_done"}, bif.stream_done, 0);
        chk({tag, "_ovf"}, bif.err_overflow, 0);
        chk({tag, "_nosos"}, bif.err_no_sos, 0);
    endtask

    task automatic fill_beats(input logic [15:0] base);
        for (int i = 0; i < 16; i++) beats[i] = base + 16'(i);
    endtask

    // Bank b waits for its grant, then streams n beats from beats[] to node.
    task automatic serve(input int b, input int node, input int n, input bit sos0,
                         input bit keep, input int stall_at);
        int  t;
        wr_t e;
        bif.bank_node_id[b*NODE_ID_W +: NODE_ID_W] = NODE_ID_W'(node);
        bif.bank_req[b] = 1'b1;
        t = 0;
        while (!bif.req_grant[b] && t < 50) begin @(posedge clk); #1; t++; end
        if (!bif.req_grant[b]) begin
            chk("grant_timeout", bif.req_grant[b], 1);
            bif.bank_req[b] = 1'b0;
            return;
        end
        chk("busy_in_grant", bif.busy, 1);
        if (!keep) bif.bank_req[b] = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && i == stall_at) begin
                bif.bank_valid[b] = 1'b0;
                bif.bank_sos[b]   = 1'b0;
                bif.bank_eos[b]   = 1'b0;
                @(posedge clk); #1;
            end
            bif.bank_valid[b] = 1'b1;
            bif.bank_sos[b]   = sos0 && (i == 0);
            bif.bank_eos[b]   = (i == n - 1);
            bif.bank_data[b*16 +: 16] = beats[i];
            if (sos0) begin
                if (i < WPN) begin
                    e.wen = 1'b1; e.addr = ADDR_W'(node * WPN + i);
                    e.data = beats[i]; e.done = (i == n - 1);
                    wq.push_back(e);
                end else if (i == n - 1) begin
                    e.wen = 1'b0; e.addr = '0; e.data = '0; e.done = 1'b1;
                    wq.push_back(e);
                end
            end
            @(posedge clk); #1;
            if (i == 0) chk("grant_one_cycle", bif.req_grant[b], 0);
        end
        bif.bank_valid[b] = 1'b0;
        bif.bank_sos[b]   = 1'b0;
        bif.bank_eos[b]   = 1'b0;
        chk("busy_after_eos", bif.busy, 0);
    endtask

    initial begin
        wr_t e;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_banks();
        fork
            monitor();
        join_none
        do_reset(3);
        chk_all_zero("reset");

        // Bank 1, node 5, four beats -> addr 40..43
        beats[0] = 16'h0102; beats[1] = 16'h0304; beats[2] = 16'h0506; beats[3] = 16'h0708;
        gq.push_back(4'b0010);
        serve(1, 5, 4, 1'b1, 1'b0, -1);

        // Banks 0 and 2 together from a fresh pointer
        do_reset(2);
        bif.bank_req = 4'b0101;
        gq.push_back(4'b0001); gq.push_back(4'b0100);
        fill_beats(16'h1000); serve(0, 10, 2, 1'b1, 1'b0, -1);
        fill_beats(16'h2000); serve(2, 11, 2, 1'b1, 1'b0, -1);

        // Same, but bank 0 keeps requesting through its stream
        do_reset(2);
        bif.bank_req = 4'b0101;
        gq.push_back(4'b0001);
        fill_beats(16'h3000); serve(0, 12, 2, 1'b1, 1'b1, -1);
`ifdef OSW_FIXED_PRIO_EN
        gq.push_back(4'b0001); gq.push_back(4'b0100);
        fill_beats(16'h3100); serve(0, 13, 2, 1'b1, 1'b0, -1);
        fill_beats(16'h3200); serve(2, 14, 2, 1'b1, 1'b0, -1);
`else
        gq.push_back(4'b0100); gq.push_back(4'b0001);
        fill_beats(16'h3200); serve(2, 14, 2, 1'b1, 1'b0, -1);
        fill_beats(16'h3100); serve(0, 13, 2, 1'b1, 1'b0, -1);
`endif

        // Single-beat stream, node 3 -> addr 24
        beats[0] = 16'hAABB;
        gq.push_back(4'b0100);
        serve(2, 3, 1, 1'b1, 1'b0, -1);

        // Missing sos: no write, sticky flag, next requester still served
        chk("nosos_before", bif.err_no_sos, 0);
        beats[0] = 16'hDEAD;
        gq.push_back(4'b1000);
        serve(3, 4, 1, 1'b0, 1'b0, -1);
        chk("nosos_set", bif.err_no_sos, 1);
        gq.push_back(4'b0010);
        fill_beats(16'h4000); serve(1, 2, 2, 1'b1, 1'b0, -1);

        // Ten beats to node 0 with a stall: writes 0..7, eos beat suppressed
        chk("ovf_before", bif.err_overflow, 0);
        gq.push_back(4'b0001);
        fill_beats(16'h5000); serve(0, 0, 10, 1'b1, 1'b0, 4);
        chk("ovf_set", bif.err_overflow, 1);
        chk("nosos_sticky", bif.err_no_sos, 1);

        // Reset during beat 2 of a 4-beat stream
        fill_beats(16'h6000);
        gq.push_back(4'b0010);
        bif.bank_node_id[1*NODE_ID_W +: NODE_ID_W] = NODE_ID_W'(7);
        bif.bank_req[1] = 1'b1;
        for (int t = 0; t < 50 && !bif.req_grant[1]; t++) begin @(posedge clk); #1; end
        chk("rst_grant_seen", bif.req_grant[1], 1);
        bif.bank_req[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bif.bank_valid[1] = 1'b1;
            bif.bank_sos[1]   = (i == 0);
            bif.bank_data[16 +: 16] = beats[i];
            if (i < 2) begin
                e.wen = 1'b1; e.addr = ADDR_W'(56 + i); e.data = beats[i]; e.done = 1'b0;
                wq.push_back(e);
            end else begin
                reset = 1'b1;
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        chk_all_zero("midrst");
        bif.bank_eos[1]  = 1'b1;
        bif.bank_data[16 +: 16] = beats[3];
        @(posedge clk); #1;
        clear_banks();
        chk("midrst_idle", bif.busy, 0);

        gq.push_back(4'b0100);
        fill_beats(16'h7000); serve(2, 1, 2, 1'b1, 1'b0, -1);

        repeat (3) begin @(posedge clk); #1; end
        chk("wq_drained", wq.size(), 0);
        chk("gq_drained", gq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/out_sram_write_arbiter.md
Name: out_sram_write_arbiter

Overview:
- Output-SRAM-side responder for the bank-to-output-buffer write-back request/grant stream protocol.
- Arbitrates write-back requests from NUM_BANKS edge buffer banks and issues a single-cycle grant to one bank.
- Captures that bank's sos/eos stream of packed feature-value pairs and writes each beat into the output SRAM at a node-indexed address.
- Sits between the edge buffer banks and the output SRAM write port.

Parameters:
NUM_BANKS, 4, number of requesting banks
FV_SIZE, 8, bits per feature value; beat width is 2*FV_SIZE
MAX_FV_NUM, 16, max feature values per node; WORDS_PER_NODE = MAX_FV_NUM/2
NODE_ID_W, 10, node id width
ADDR_W, NODE_ID_W+$clog2(MAX_FV_NUM/2), SRAM word address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
bank_req  in  NUM_BANKS  per-bank write-back request
bank_valid  in  NUM_BANKS  per-bank Grant_valid (beat valid)
bank_sos  in  NUM_BANKS  per-bank start of stream
bank_eos  in  NUM_BANKS  per-bank end of stream
bank_data  in  NUM_BANKS*2*FV_SIZE  per-bank beat; [15:8]=even FV, [7:0]=odd FV
bank_node_id  in  NUM_BANKS*NODE_ID_W  per-bank node id
req_grant  out  NUM_BANKS  one-hot single-cycle grant, registered
sram_wen  out  1  SRAM write enable, registered
sram_waddr  out  ADDR_W  SRAM write address
sram_wdata  out  2*FV_SIZE  SRAM write data
busy  out  1  high whenever state != IDLE
stream_done  out  1  one-cycle pulse, same cycle as the eos beat's SRAM write
err_overflow  out  1  sticky overflow flag; cleared only by reset
err_no_sos  out  1  sticky flag for a missing sos beat in GRANT; cleared only by reset

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values:
  - All outputs 0, state=IDLE.
  - Round-robin pointer rr_ptr=0, beat offset off=0, locked index idx=0.
- IDLE:
  - If any bank_req is set, select the first requester at or after rr_ptr, searching cyclically.
  - Latch the winner in idx, drive req_grant[idx]=1 (registered), and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (req_grant[idx] high for exactly this one cycle; the bank answers combinationally in the same cycle):
  - If bank_valid[idx] and bank_sos[idx] are both set:
    - Latch base = bank_node_id[idx]*WORDS_PER_NODE.
    - Write the beat at base+0 and set off=1.
    - If bank_eos[idx] is also set: go to IDLE with rr_ptr=idx+1 (mod NUM_BANKS). Otherwise go to RECV.
  - Else (no sos beat): set err_no_sos, go to IDLE, rr_ptr=idx+1. No write occurs.
- RECV:
  - Only signals of bank idx are sampled; other requests wait.
  - bank_valid[idx]=0: stall, no write, no timeout.
  - bank_valid[idx]=1 and off<WORDS_PER_NODE: write at base+off, then off++.
  - bank_valid[idx]=1 and off==WORDS_PER_NODE: suppress the write, set err_overflow, do not increment off.
  - bank_sos seen again in RECV is ignored (treated as a data beat).
  - bank_eos[idx] with a valid beat: process that beat as above, then go to IDLE with off=0 and rr_ptr=idx+1.
- SRAM write timing:
  - sram_wen/waddr/wdata are registered, so the write appears 1 cycle after the beat.
  - stream_done pulses with the eos beat's write; if that write was suppressed it pulses in the same cycle anyway.
- Throughput:
  - Minimum stream-to-stream gap is 2 cycles (IDLE → GRANT).
  - A requester holding req is served within NUM_BANKS streams.
- req_grant is never asserted in RECV or IDLE and is never multi-hot.
- Reset mid-stream: abort immediately. No further writes; the partial stream is not rolled back.
- Widths: the address is concatenation {node_id, off[$clog2(WORDS_PER_NODE)-1:0]}; no arithmetic overflow is possible.

Optional Feature:
OSW_FIXED_PRIO_EN
- Defined: fixed priority, lowest asserted bank_req index wins; rr_ptr is unused and held at 0.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Bank 1 reqs, node_id=5, 4 beats (sos on beat 0, eos on beat 3, data 0x0102,0x0304,0x0506,0x0708) → req_grant=0010 for one cycle; writes to addr 40..43 with that data; stream_done on the 4th write; busy drops the next cycle.
- Banks 0 and 2 req together, each with a 2-beat stream → bank 0 served first, then bank 2. Repeat with bank 0 re-requesting: the next grant goes to bank 2 under round-robin; with OSW_FIXED_PRIO_EN it goes to bank 0.
- Single-beat stream (sos+eos in the GRANT cycle), node 3, data 0xAABB → exactly one write, addr 24 data 0xAABB; back in IDLE in 1 cycle.
- Granted bank does not drive sos in GRANT → err_no_sos=1, no write, and the next requester is granted.
- 9 valid beats to node 0 before eos → writes at addr 0..7 only, err_overflow=1, stream_done at the eos beat.
- Reset asserted during beat 2 of a 4-beat stream → next cycle all outputs 0, state IDLE; later beats produce no writes; a fresh request is served normally afterwards.
